// File: rtl/qspi_cmd_arbiter.sv
// Arbitrates the CSR and XIP requesters onto one QSPI command engine, latches the winning command,
// starts the engine, routes completion back to the owner and aborts transactions that time out.
module qspi_cmd_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csr_req_i,
  input  logic [15:0]           csr_cfg_i,
  input  logic [7:0]            csr_opcode_i,
  input  logic [ADDR_WIDTH-1:0] csr_addr_i,
  input  logic [31:0]           csr_len_i,
  input  logic                  csr_is_write_i,
  output logic                  csr_ack_o,
  output logic                  csr_done_o,
  input  logic                  xip_req_i,
  input  logic [15:0]           xip_cfg_i,
  input  logic [7:0]            xip_opcode_i,
  input  logic [ADDR_WIDTH-1:0] xip_addr_i,
  input  logic [31:0]           xip_len_i,
  output logic                  xip_ack_o,
  output logic                  xip_done_o,
  output logic                  eng_start_o,
  input  logic                  eng_busy_i,
  input  logic                  eng_done_i,
  output logic                  eng_abort_o,
  output logic [15:0]           eng_cfg_o,
  output logic [7:0]            eng_opcode_o,
  output logic [ADDR_WIDTH-1:0] eng_addr_o,
  output logic [31:0]           eng_len_o,
  output logic                  eng_is_write_o,
  input  logic [15:0]           timeout_cycles_i,
  input  logic                  err_clr_i,
  output logic                  err_timeout_o,
  output logic                  done_err_o,
  output logic                  owner_o,
  output logic                  busy_o
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                state_q, state_d;
  logic [3:0]            starve_q, starve_d;
  logic [15:0]           tcnt_q, tcnt_d;
  logic                  csr_ack_q, csr_ack_d, csr_done_q, csr_done_d;
  logic                  xip_ack_q, xip_ack_d, xip_done_q, xip_done_d;
  logic                  start_q, start_d, abort_q, abort_d;
  logic                  done_err_q, done_err_d, err_q, err_d, owner_q, owner_d;
  logic [15:0]           cfg_q, cfg_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           len_q, len_d;
  logic                  wr_q, wr_d;
  logic                  grant_xip, grant_csr, finish, timed_out;

  // XIP has priority until a waiting CSR request has been passed over StarveLim times.
  assign grant_xip = xip_req_i && !(csr_req_i && (starve_q == StarveLim));
  assign grant_csr = csr_req_i && !grant_xip;
  assign timed_out = (timeout_cycles_i != 16'd0) && (tcnt_q == timeout_cycles_i - 16'd1);

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    tcnt_d     = tcnt_q;
    csr_ack_d  = 1'b0;
    csr_done_d = 1'b0;
    xip_ack_d  = 1'b0;
    xip_done_d = 1'b0;
    start_d    = 1'b0;
    abort_d    = 1'b0;
    done_err_d = 1'b0;
    err_d      = err_clr_i ? 1'b0 : err_q;
    owner_d    = owner_q;
    cfg_d      = cfg_q;
    opcode_d   = opcode_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wr_d       = wr_q;
    finish     = 1'b0;

    case (state_q)
      StIdle: begin
        if (grant_xip) begin
          state_d   = StIssue;
          owner_d   = 1'b1;
          xip_ack_d = 1'b1;
          cfg_d     = xip_cfg_i;
          opcode_d  = xip_opcode_i;
          addr_d    = xip_addr_i;
          len_d     = xip_len_i;
          wr_d      = 1'b0;
        end else if (grant_csr) begin
          state_d   = StIssue;
          owner_d   = 1'b0;
          csr_ack_d = 1'b1;
          cfg_d     = csr_cfg_i;
          opcode_d  = csr_opcode_i;
          addr_d    = csr_addr_i;
          len_d     = csr_len_i;
          wr_d      = csr_is_write_i;
        end
      end
      StIssue: begin
        if (!eng_busy_i) begin
          state_d = StWait;
          start_d = 1'b1;
          tcnt_d  = 16'd0;
        end
      end
      StWait: begin
        if (eng_done_i) begin
          finish = 1'b1;
        end else if (timed_out) begin
          finish     = 1'b1;
          abort_d    = 1'b1;
          done_err_d = 1'b1;
          err_d      = 1'b1;
        end else if (tcnt_q != 16'hFFFF) begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (finish) begin
      state_d    = StIdle;
      csr_done_d = !owner_q;
      xip_done_d = owner_q;
    end

    if (!csr_req_i || csr_ack_d) begin
      starve_d = 4'd0;
    end else if (xip_ack_d && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      starve_q   <= 4'd0;
      tcnt_q     <= 16'd0;
      csr_ack_q  <= 1'b0;
      csr_done_q <= 1'b0;
      xip_ack_q  <= 1'b0;
      xip_done_q <= 1'b0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      done_err_q <= 1'b0;
      err_q      <= 1'b0;
      owner_q    <= 1'b0;
      cfg_q      <= 16'd0;
      opcode_q   <= 8'd0;
      addr_q     <= '0;
      len_q      <= 32'd0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      tcnt_q     <= tcnt_d;
      csr_ack_q  <= csr_ack_d;
      csr_done_q <= csr_done_d;
      xip_ack_q  <= xip_ack_d;
      xip_done_q <= xip_done_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      done_err_q <= done_err_d;
      err_q      <= err_d;
      owner_q    <= owner_d;
      cfg_q      <= cfg_d;
      opcode_q   <= opcode_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wr_q       <= wr_d;
    end
  end

  assign csr_ack_o      = csr_ack_q;
  assign csr_done_o     = csr_done_q;
  assign xip_ack_o      = xip_ack_q;
  assign xip_done_o     = xip_done_q;
  assign eng_start_o    = start_q;
  assign eng_abort_o    = abort_q;
  assign done_err_o     = done_err_q;
  assign err_timeout_o  = err_q;
  assign owner_o        = owner_q;
  assign busy_o         = (state_q != StIdle);
  assign eng_cfg_o      = cfg_q;
  assign eng_opcode_o   = opcode_q;
  assign eng_addr_o     = addr_q;
  assign eng_len_o      = len_q;
  assign eng_is_write_o = wr_q;

endmodule

// File: tb/tb_qspi_cmd_arbiter.sv
// Self-checking bench for qspi_cmd_arbiter: table of single transactions with expected latencies,
// a grant-order scoreboard under contention, and a reset in the middle of a wait.
module tb_qspi_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_req_i, csr_is_write_i, csr_ack_o, csr_done_o;
  logic [15:0] csr_cfg_i, xip_cfg_i, eng_cfg_o, timeout_cycles_i;
  logic [7:0]  csr_opcode_i, xip_opcode_i, eng_opcode_o;
  logic [31:0] csr_addr_i, csr_len_i, xip_addr_i, xip_len_i, eng_addr_o, eng_len_o;
  logic        xip_req_i, xip_ack_o, xip_done_o;
  logic        eng_start_o, eng_busy_i, eng_done_i, eng_abort_o, eng_is_write_o;
  logic        err_clr_i, err_timeout_o, done_err_o, owner_o, busy_o;

  qspi_cmd_arbiter #(
    .ADDR_WIDTH  (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .csr_req_i       (csr_req_i),
    .csr_cfg_i       (csr_cfg_i),
    .csr_opcode_i    (csr_opcode_i),
    .csr_addr_i      (csr_addr_i),
    .csr_len_i       (csr_len_i),
    .csr_is_write_i  (csr_is_write_i),
    .csr_ack_o       (csr_ack_o),
    .csr_done_o      (csr_done_o),
    .xip_req_i       (xip_req_i),
    .xip_cfg_i       (xip_cfg_i),
    .xip_opcode_i    (xip_opcode_i),
    .xip_addr_i      (xip_addr_i),
    .xip_len_i       (xip_len_i),
    .xip_ack_o       (xip_ack_o),
    .xip_done_o      (xip_done_o),
    .eng_start_o     (eng_start_o),
    .eng_busy_i      (eng_busy_i),
    .eng_done_i      (eng_done_i),
    .eng_abort_o     (eng_abort_o),
    .eng_cfg_o       (eng_cfg_o),
    .eng_opcode_o    (eng_opcode_o),
    .eng_addr_o      (eng_addr_o),
    .eng_len_o       (eng_len_o),
    .eng_is_write_o  (eng_is_write_o),
    .timeout_cycles_i(timeout_cycles_i),
    .err_clr_i       (err_clr_i),
    .err_timeout_o   (err_timeout_o),
    .done_err_o      (done_err_o),
    .owner_o         (owner_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          owner;
    logic [15:0] cfg;
    logic [7:0]  opc;
    logic [31:0] addr;
    logic [31:0] len;
    bit          wr;
    int          busy_cyc;
    int          done_dly;  // cycles after start that eng_done_i is driven; 0 = never
    logic [15:0] tmo;
    int          exp_start;
    int          exp_done;
    bit          exp_err;
    bit          exp_wr;
  } vec_t;

  typedef struct {
    bit          owner;
    logic [15:0] cfg;
    logic [7:0]  opc;
    logic [31:0] addr;
    logic [31:0] len;
    bit          wr;
    bit          err;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[7];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_start = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Observes acks/dones against the scoreboard front; called once per cycle from tick().
  task automatic monitor();
    sb_t e;
    if (reset) return;
    if (eng_start_o) n_start++;
    if (csr_ack_o || xip_ack_o) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_ack", 64'(1), 64'(0));
      end else begin
        e = sb[0];
        chk("ack_who", 64'({xip_ack_o, csr_ack_o}), 64'(e.owner ? 2'b10 : 2'b01));
        chk("ack_owner", 64'(owner_o), 64'(e.owner));
        chk("ack_cfg", 64'(eng_cfg_o), 64'(e.cfg));
        chk("ack_opcode", 64'(eng_opcode_o), 64'(e.opc));
        chk("ack_addr", 64'(eng_addr_o), 64'(e.addr));
        chk("ack_len", 64'(eng_len_o), 64'(e.len));
        chk("ack_is_write", 64'(eng_is_write_o), 64'(e.wr));
      end
    end
    if (csr_done_o || xip_done_o) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("done_who", 64'({xip_done_o, csr_done_o}), 64'(e.owner ? 2'b10 : 2'b01));
        chk("done_err", 64'(done_err_o), 64'(e.err));
        chk("done_opcode", 64'(eng_opcode_o), 64'(e.opc));
        chk("done_addr", 64'(eng_addr_o), 64'(e.addr));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic drive_req(input vec_t v);
    if (v.owner) begin
      xip_req_i = 1'b1; xip_cfg_i = v.cfg; xip_opcode_i = v.opc;
      xip_addr_i = v.addr; xip_len_i = v.len;
    end else begin
      csr_req_i = 1'b1; csr_cfg_i = v.cfg; csr_opcode_i = v.opc;
      csr_addr_i = v.addr; csr_len_i = v.len; csr_is_write_i = v.wr;
    end
    sb.push_back('{v.owner, v.cfg, v.opc, v.addr, v.len, v.exp_wr, v.exp_err});
  endtask

  task automatic run_row(input vec_t v, input int idx);
    int  t;
    int  k;
    int  s0;
    bit  seen;
    timeout_cycles_i = v.tmo;
    s0 = n_start;
    drive_req(v);
    tick();
    chk($sformatf("row%0d_ack", idx), 64'(v.owner ? xip_ack_o : csr_ack_o), 64'(1));
    chk($sformatf("row%0d_busy", idx), 64'(busy_o), 64'(1));
    csr_req_i = 1'b0;
    xip_req_i = 1'b0;
    t = 1;
    while (!eng_start_o && t < 30) begin
      eng_busy_i = (t <= v.busy_cyc);
      tick();
      t++;
    end
    eng_busy_i = 1'b0;
    chk($sformatf("row%0d_start_lat", idx), 64'(t), 64'(v.exp_start));
    seen = 1'b0;
    k = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      eng_done_i = (v.done_dly != 0) && (i - 1 == v.done_dly);
      tick();
      eng_done_i = 1'b0;
      if (csr_done_o || xip_done_o) begin
        seen = 1'b1;
        k = i;
      end
    end
    chk($sformatf("row%0d_done_lat", idx), 64'(k), 64'(v.exp_done));
    chk($sformatf("row%0d_abort", idx), 64'(eng_abort_o), 64'(v.exp_err));
    chk($sformatf("row%0d_err_flag", idx), 64'(err_timeout_o), 64'(v.exp_err));
    chk($sformatf("row%0d_busy_end", idx), 64'(busy_o), 64'(0));
    chk($sformatf("row%0d_starts", idx), 64'(n_start - s0), 64'(1));
    if (v.exp_err) begin
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk($sformatf("row%0d_err_clr", idx), 64'(err_timeout_o), 64'(0));
    end
    tick();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_flags"}, 64'({csr_ack_o, csr_done_o, xip_ack_o, xip_done_o, eng_start_o,
                             eng_abort_o, done_err_o, owner_o, busy_o, err_timeout_o}), 64'(0));
    chk({nm, "_cfg_opc_wr"}, 64'({eng_cfg_o, eng_opcode_o, eng_is_write_o}), 64'(0));
    chk({nm, "_addr"}, 64'(eng_addr_o), 64'(0));
    chk({nm, "_len"}, 64'(eng_len_o), 64'(0));
  endtask

  initial begin
    int   acks;
    sb_t  xe;
    sb_t  ce;
    //           own cfg       opc    addr          len  wr bsy dly tmo  st dn er ewr
    tbl[0] = '{1'b0, 16'hA5C3, 8'h9F, 32'h0,        3,   1'b0, 0, 10, 0, 2, 11, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'h1234, 8'h02, 32'h00123456, 256, 1'b1, 5, 4,  0, 7, 5,  1'b0, 1'b1};
    tbl[2] = '{1'b1, 16'hEB0F, 8'hEB, 32'h00ABCDEF, 32,  1'b1, 0, 0,  8, 2, 8,  1'b1, 1'b0};
    tbl[3] = '{1'b1, 16'h6B01, 8'h6B, 32'h00000040, 64,  1'b0, 0, 7,  8, 2, 8,  1'b0, 1'b0};
    tbl[4] = '{1'b0, 16'h0300, 8'h05, 32'hFFFFFFFC, 1,   1'b0, 0, 3,  8, 2, 4,  1'b0, 1'b0};
    tbl[5] = '{1'b0, 16'hFFFF, 8'h0B, 32'h80000000, 8,   1'b0, 0, 0,  1, 2, 1,  1'b1, 1'b0};
    tbl[6] = '{1'b1, 16'h5A5A, 8'hBB, 32'h00001000, 16,  1'b0, 2, 1,  0, 4, 2,  1'b0, 1'b0};

    reset = 1'b1;
    csr_req_i = 0; csr_cfg_i = 0; csr_opcode_i = 0; csr_addr_i = 0; csr_len_i = 0;
    csr_is_write_i = 0; xip_req_i = 0; xip_cfg_i = 0; xip_opcode_i = 0; xip_addr_i = 0;
    xip_len_i = 0; eng_busy_i = 0; eng_done_i = 0; timeout_cycles_i = 0; err_clr_i = 0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_all_zero("reset");

    for (int i = 0; i < 7; i++) run_row(tbl[i], i);

    // Contention: both held high; expect XIP x4, CSR, XIP x4, CSR.
    timeout_cycles_i = 0;
    xe = '{1'b1, 16'hEB00, 8'hEB, 32'h00002000, 32'd16, 1'b0, 1'b0};
    ce = '{1'b0, 16'h0F0F, 8'h05, 32'h00000100, 32'd1, 1'b0, 1'b0};
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) sb.push_back(xe);
      sb.push_back(ce);
    end
    xip_req_i = 1'b1; xip_cfg_i = xe.cfg; xip_opcode_i = xe.opc;
    xip_addr_i = xe.addr; xip_len_i = xe.len;
    csr_req_i = 1'b1; csr_cfg_i = ce.cfg; csr_opcode_i = ce.opc;
    csr_addr_i = ce.addr; csr_len_i = ce.len; csr_is_write_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      eng_done_i = eng_start_o;
      tick();
      eng_done_i = 1'b0;
      if (csr_ack_o || xip_ack_o) begin
        acks++;
        if (acks == 10) begin
          csr_req_i = 1'b0;
          xip_req_i = 1'b0;
        end
      end
    end
    csr_req_i = 1'b0;
    xip_req_i = 1'b0;
    chk("contention_drained", 64'(sb.size()), 64'(0));
    chk("contention_acks", 64'(acks), 64'(10));
    tick();
    tick();

    // Reset while waiting on the engine: no done/abort, then a clean restart.
    timeout_cycles_i = 16'd20;
    drive_req(tbl[0]);
    tick();
    csr_req_i = 1'b0;
    tick();
    chk("rst_mid_started", 64'(eng_start_o), 64'(1));
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    reset = 1'b0;
    sb.delete();
    tick();
    chk("rst_mid_no_done", 64'({csr_done_o, xip_done_o, eng_abort_o}), 64'(0));
    run_row(tbl[0], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
